// File: rtl/mult_arbiter_pkg.sv
// rtl/mult_arbiter_pkg.sv - state encoding, client indices and grant helper for mult_arbiter
package mult_arbiter_pkg;

  localparam logic [1:0] IDLE      = 2'd0;
  localparam logic [1:0] ISSUE     = 2'd1;
  localparam logic [1:0] WAIT_BUSY = 2'd2;
  localparam logic [1:0] WAIT_DONE = 2'd3;

  localparam logic CL0 = 1'b0;
  localparam logic CL1 = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE      = IDLE,
    S_ISSUE     = ISSUE,
    S_WAIT_BUSY = WAIT_BUSY,
    S_WAIT_DONE = WAIT_DONE
  } state_t;

  // Round-robin choice: a lone requester always wins, a tie goes to the client not served last.
  function automatic logic rr_pick(input logic pend0, input logic pend1, input logic last_grant);
    logic pick;
    if (pend0 && pend1) begin
      pick = (last_grant == CL0) ? CL1 : CL0;
    end else if (pend1) begin
      pick = CL1;
    end else begin
      pick = CL0;
    end
    return pick;
  endfunction

endpackage

// File: rtl/mult_arbiter_if.sv
// rtl/mult_arbiter_if.sv - client ports and shared mult port bundled for mult_arbiter
interface mult_arbiter_if #(
  parameter int WIDTH = 8
);

  logic [WIDTH-1:0]   a0_bi;
  logic [WIDTH-1:0]   b0_bi;
  logic               start0_i;
  logic               busy0_o;
  logic [2*WIDTH-1:0] y0_bo;

  logic [WIDTH-1:0]   a1_bi;
  logic [WIDTH-1:0]   b1_bi;
  logic               start1_i;
  logic               busy1_o;
  logic [2*WIDTH-1:0] y1_bo;

  logic [WIDTH-1:0]   mul_a_bo;
  logic [WIDTH-1:0]   mul_b_bo;
  logic               mul_start_o;
  logic               mul_busy_i;
  logic [2*WIDTH-1:0] mul_y_bi;

  modport slave (
    input  a0_bi, b0_bi, start0_i,
    output busy0_o, y0_bo,
    input  a1_bi, b1_bi, start1_i,
    output busy1_o, y1_bo,
    output mul_a_bo, mul_b_bo, mul_start_o,
    input  mul_busy_i, mul_y_bi
  );

  modport master (
    output a0_bi, b0_bi, start0_i,
    input  busy0_o, y0_bo,
    output a1_bi, b1_bi, start1_i,
    input  busy1_o, y1_bo,
    input  mul_a_bo, mul_b_bo, mul_start_o,
    output mul_busy_i, mul_y_bi
  );

endinterface

// File: rtl/mult_arb_slot.sv
// rtl/mult_arb_slot.sv - one client request slot: latched operands, pending/busy flag, held result
module mult_arb_slot #(
  parameter int WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic [WIDTH-1:0]   a_bi,
  input  logic [WIDTH-1:0]   b_bi,
  input  logic               start_i,
  input  logic               complete_i,
  input  logic [2*WIDTH-1:0] res_bi,
  output logic [WIDTH-1:0]   a_bo,
  output logic [WIDTH-1:0]   b_bo,
  output logic               busy_o,
  output logic [2*WIDTH-1:0] y_bo
);

  logic capture;

  // A start while already pending is dropped so queued operands are never overwritten.
  assign capture = start_i && !busy_o;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      a_bo   <= '0;
      b_bo   <= '0;
      busy_o <= 1'b0;
      y_bo   <= '0;
    end else begin
      if (capture) begin
        a_bo   <= a_bi;
        b_bo   <= b_bi;
        busy_o <= 1'b1;
      end else if (complete_i) begin
        busy_o <= 1'b0;
      end
      if (complete_i) begin
        y_bo <= res_bi;
      end
    end
  end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one start/busy multiplier between two clients with round-robin grants
module mult_arbiter
  import mult_arbiter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic           clk_i,
  input  logic           rst_i,
  mult_arbiter_if.slave  bus
);

  state_t             state_q, state_d;
  logic               grant_q, grant_d;
  logic               last_grant_q, last_grant_d;
  logic               mul_start_q, mul_start_d;
  logic [WIDTH-1:0]   mul_a_q, mul_a_d;
  logic [WIDTH-1:0]   mul_b_q, mul_b_d;

  logic               pend0, pend1;
  logic               cmp0, cmp1;
  logic [WIDTH-1:0]   op_a0, op_b0, op_a1, op_b1;
  logic [2*WIDTH-1:0] y0, y1;

  mult_arb_slot #(.WIDTH(WIDTH)) u_slot0 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_bi       (bus.a0_bi),
    .b_bi       (bus.b0_bi),
    .start_i    (bus.start0_i),
    .complete_i (cmp0),
    .res_bi     (bus.mul_y_bi),
    .a_bo       (op_a0),
    .b_bo       (op_b0),
    .busy_o     (pend0),
    .y_bo       (y0)
  );

  mult_arb_slot #(.WIDTH(WIDTH)) u_slot1 (
    .clk_i      (clk_i),
    .rst_i      (rst_i),
    .a_bi       (bus.a1_bi),
    .b_bi       (bus.b1_bi),
    .start_i    (bus.start1_i),
    .complete_i (cmp1),
    .res_bi     (bus.mul_y_bi),
    .a_bo       (op_a1),
    .b_bo       (op_b1),
    .busy_o     (pend1),
    .y_bo       (y1)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      grant_q      <= CL0;
      last_grant_q <= CL1;
      mul_start_q  <= 1'b0;
      mul_a_q      <= '0;
      mul_b_q      <= '0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      mul_start_q  <= mul_start_d;
      mul_a_q      <= mul_a_d;
      mul_b_q      <= mul_b_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    mul_start_d  = 1'b0;
    mul_a_d      = mul_a_q;
    mul_b_d      = mul_b_q;
    cmp0         = 1'b0;
    cmp1         = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pend0 || pend1) begin
          grant_d     = rr_pick(pend0, pend1, last_grant_q);
          mul_a_d     = (grant_d == CL1) ? op_a1 : op_a0;
          mul_b_d     = (grant_d == CL1) ? op_b1 : op_b0;
          mul_start_d = 1'b1;
          state_d     = S_ISSUE;
        end
      end
      S_ISSUE: begin
        state_d = S_WAIT_BUSY;
      end
      // The mult may raise busy several cycles after sampling start.
      S_WAIT_BUSY: begin
        if (bus.mul_busy_i) begin
          state_d = S_WAIT_DONE;
        end
      end
      S_WAIT_DONE: begin
        if (!bus.mul_busy_i) begin
          cmp0         = (grant_q == CL0);
          cmp1         = (grant_q == CL1);
          last_grant_d = grant_q;
          state_d      = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign bus.mul_a_bo    = mul_a_q;
  assign bus.mul_b_bo    = mul_b_q;
  assign bus.mul_start_o = mul_start_q;
  assign bus.busy0_o     = pend0;
  assign bus.busy1_o     = pend1;
  assign bus.y0_bo       = y0;
  assign bus.y1_bo       = y1;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - randomized scoreboard bench for mult_arbiter with a behavioural mult
module tb_mult_arbiter;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    bit           ign;
  } req_t;

  logic clk = 1'b0;
  logic rst_i = 1'b1;

  mult_arbiter_if #(.WIDTH(W)) bus ();

  mult_arbiter #(.WIDTH(W)) dut (
    .clk_i (clk),
    .rst_i (rst_i),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  req_t           rq[2][$];
  logic [2*W-1:0] exp_q[2][$];
  bit             pend[2];
  bit             issued[2];
  int             acc[2];
  logic [W-1:0]   opa[2];
  logic [W-1:0]   opb[2];
  logic [2*W-1:0] model_y[2];
  int             last_gm = 1;
  int             free_edge = 0;
  bit             srv_active = 0;
  int             in_srv = 0;
  int             tx_cnt = 0;
  int             cmp_order[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Behavioural multiplier: busy rises 1..3 cycles after start and lasts 1..4 cycles.
  logic [2*W-1:0] m_prod;
  int             m_dly, m_run;
  always @(posedge clk or posedge rst_i) begin
    if (rst_i) begin
      bus.mul_busy_i <= 1'b0;
      bus.mul_y_bi   <= '0;
      m_prod         <= '0;
      m_dly          <= 0;
      m_run          <= 0;
    end else if (m_dly != 0) begin
      if (m_dly == 1) bus.mul_busy_i <= 1'b1;
      m_dly <= m_dly - 1;
    end else if (bus.mul_busy_i) begin
      if (m_run <= 1) begin
        bus.mul_busy_i <= 1'b0;
        bus.mul_y_bi   <= m_prod;
      end
      m_run <= m_run - 1;
    end else if (bus.mul_start_o) begin
      m_prod <= (2*W)'(bus.mul_a_bo) * (2*W)'(bus.mul_b_bo);
      m_dly  <= 1 + int'($urandom_range(0, 2));
      m_run  <= int'($urandom_range(1, 4));
    end
  end

  // Client 0 driver
  initial begin
    req_t r;
    bus.start0_i = 1'b0;
    bus.a0_bi    = '0;
    bus.b0_bi    = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.start0_i = 1'b0;
      bus.a0_bi    = W'($urandom);
      bus.b0_bi    = W'($urandom);
      if (!rst_i && rq[0].size() != 0 && (!pend[0] || rq[0][0].ign)) begin
        r = rq[0].pop_front();
        if (!r.ign) begin
          pend[0] = 1'b1;
          acc[0]  = cyc + 1;
          opa[0]  = r.a;
          opb[0]  = r.b;
          exp_q[0].push_back((2*W)'(r.a) * (2*W)'(r.b));
        end
        if (!r.ign || pend[0]) begin
          bus.a0_bi    = r.a;
          bus.b0_bi    = r.b;
          bus.start0_i = 1'b1;
        end
      end
    end
  end

  // Client 1 driver
  initial begin
    req_t r;
    bus.start1_i = 1'b0;
    bus.a1_bi    = '0;
    bus.b1_bi    = '0;
    forever begin
      @(posedge clk);
      #1;
      bus.start1_i = 1'b0;
      bus.a1_bi    = W'($urandom);
      bus.b1_bi    = W'($urandom);
      if (!rst_i && rq[1].size() != 0 && (!pend[1] || rq[1][0].ign)) begin
        r = rq[1].pop_front();
        if (!r.ign) begin
          pend[1] = 1'b1;
          acc[1]  = cyc + 1;
          opa[1]  = r.a;
          opb[1]  = r.b;
          exp_q[1].push_back((2*W)'(r.a) * (2*W)'(r.b));
        end
        if (!r.ign || pend[1]) begin
          bus.a1_bi    = r.a;
          bus.b1_bi    = r.b;
          bus.start1_i = 1'b1;
        end
      end
    end
  end

  // Monitor: grants, issue timing, operand routing, completions and held results
  initial begin
    logic           bz[2];
    logic           prev_b[2];
    logic [2*W-1:0] yy[2];
    logic           prev_start;
    bit             c0, c1;
    int             g, e, earliest;
    prev_b[0] = 1'b0;
    prev_b[1] = 1'b0;
    prev_start = 1'b0;
    forever begin
      @(negedge clk);
      bz[0] = bus.busy0_o;
      bz[1] = bus.busy1_o;
      yy[0] = bus.y0_bo;
      yy[1] = bus.y1_bo;
      if (rst_i) begin
        prev_b[0] = 1'b0;
        prev_b[1] = 1'b0;
        prev_start = 1'b0;
      end else begin
        if (prev_start) begin
          chk("start_one_cycle", 32'(bus.mul_start_o), 0);
        end else if (bus.mul_start_o) begin
          tx_cnt++;
          c0 = pend[0] && !issued[0] && acc[0] < cyc;
          c1 = pend[1] && !issued[1] && acc[1] < cyc;
          if (!c0 && !c1) begin
            chk("spurious_issue", 1, 0);
          end else begin
            g = (c0 && c1) ? (last_gm == 0 ? 1 : 0) : (c1 ? 1 : 0);
            earliest = (c0 && c1) ? ((acc[0] < acc[1]) ? acc[0] : acc[1]) : acc[g];
            e = (earliest + 1 > free_edge) ? earliest + 1 : free_edge;
            chk("issue_edge", 32'(cyc), 32'(e));
            chk("issue_a", 32'(bus.mul_a_bo), 32'(opa[g]));
            chk("issue_b", 32'(bus.mul_b_bo), 32'(opb[g]));
            issued[g]  = 1'b1;
            in_srv     = g;
            srv_active = 1'b1;
          end
        end else if (srv_active) begin
          chk("op_stable_a", 32'(bus.mul_a_bo), 32'(opa[in_srv]));
          chk("op_stable_b", 32'(bus.mul_b_bo), 32'(opb[in_srv]));
        end
        for (int k = 0; k < 2; k++) begin
          if (prev_b[k] && !bz[k]) begin
            chk("cmp_owner", 32'(k), srv_active ? 32'(in_srv) : 32'd9);
            if (exp_q[k].size() == 0) chk("cmp_unexpected", 1, 0);
            else model_y[k] = exp_q[k].pop_front();
            pend[k]    = 1'b0;
            issued[k]  = 1'b0;
            srv_active = 1'b0;
            last_gm    = k;
            free_edge  = cyc + 1;
            cmp_order.push_back(k);
          end
        end
        for (int k = 0; k < 2; k++) begin
          chk((k == 0) ? "y0_value" : "y1_value", 32'(yy[k]), 32'(model_y[k]));
          if (!pend[k]) chk((k == 0) ? "busy0_idle" : "busy1_idle", 32'(bz[k]), 0);
          else if (acc[k] <= cyc) chk((k == 0) ? "busy0_held" : "busy1_held", 32'(bz[k]), 1);
        end
        prev_b[0] = bz[0];
        prev_b[1] = bz[1];
        prev_start = bus.mul_start_o;
      end
    end
  end

  task automatic clear_model();
    for (int k = 0; k < 2; k++) begin
      rq[k].delete();
      exp_q[k].delete();
      pend[k]    = 1'b0;
      issued[k]  = 1'b0;
      model_y[k] = '0;
    end
    last_gm    = 1;
    free_edge  = 0;
    srv_active = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_y0"}, 32'(bus.y0_bo), 0);
    chk({tag, "_y1"}, 32'(bus.y1_bo), 0);
    chk({tag, "_busy0"}, 32'(bus.busy0_o), 0);
    chk({tag, "_busy1"}, 32'(bus.busy1_o), 0);
    chk({tag, "_mul_start"}, 32'(bus.mul_start_o), 0);
    chk({tag, "_mul_a"}, 32'(bus.mul_a_bo), 0);
    chk({tag, "_mul_b"}, 32'(bus.mul_b_bo), 0);
  endtask

  task automatic do_reset(input string tag);
    rst_i = 1'b1;
    clear_model();
    #1;
    check_zero(tag);
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((rq[0].size() + rq[1].size() + exp_q[0].size() + exp_q[1].size()) != 0
           || pend[0] || pend[1]) begin
      @(posedge clk);
      n++;
      if (n > 2000) begin
        checks++;
        errors++;
        $display("FAIL %s_timeout: got no completion expected drain within 2000 cycles", name);
        break;
      end
    end
    repeat (2) @(posedge clk);
  endtask

  function automatic req_t mk(input int a, input int b, input bit ign);
    req_t r;
    r.a   = W'(a);
    r.b   = W'(b);
    r.ign = ign;
    return r;
  endfunction

  initial begin
    int t0, n;
    clear_model();
    #1;
    check_zero("reset");
    repeat (2) @(posedge clk);
    #2;
    rst_i = 1'b0;

    // Single request on client 0
    rq[0].push_back(mk(13, 11, 0));
    wait_drain("t1");
    chk("t1_y0", 32'(bus.y0_bo), 143);
    chk("t1_y1", 32'(bus.y1_bo), 0);

    // Simultaneous start right after reset
    @(posedge clk);
    #2;
    do_reset("t2_reset");
    cmp_order.delete();
    rq[0].push_back(mk(255, 255, 0));
    rq[1].push_back(mk(54, 54, 0));
    wait_drain("t2");
    chk("t2_y0", 32'(bus.y0_bo), 65025);
    chk("t2_y1", 32'(bus.y1_bo), 2916);
    chk("t2_count", 32'(cmp_order.size()), 2);
    if (cmp_order.size() == 2) begin
      chk("t2_first", 32'(cmp_order[0]), 0);
      chk("t2_second", 32'(cmp_order[1]), 1);
    end

    // Continuous requests from both clients alternate grants
    cmp_order.delete();
    rq[0].push_back(mk(3, 7, 0));
    rq[1].push_back(mk(9, 9, 0));
    for (int i = 0; i < 2; i++) begin
      rq[0].push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0));
      rq[1].push_back(mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0));
    end
    wait_drain("t3");
    chk("t3_count", 32'(cmp_order.size()), 6);
    if (cmp_order.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t3_order", 32'(cmp_order[i]), 32'(i % 2));
    end

    // Start while busy is ignored
    t0 = tx_cnt;
    rq[1].push_back(mk(4, 5, 0));
    rq[1].push_back(mk(2, 2, 1));
    wait_drain("t4");
    chk("t4_y1", 32'(bus.y1_bo), 20);
    chk("t4_tx_count", 32'(tx_cnt - t0), 1);

    // Reset while waiting for the mult to finish
    rq[0].push_back(mk(100, 2, 0));
    n = 0;
    while (!bus.mul_busy_i && n < 200) begin
      @(posedge clk);
      n++;
    end
    chk("t5_mult_busy_seen", 32'(bus.mul_busy_i), 1);
    @(posedge clk);
    #1;
    do_reset("t5_reset");
    rq[0].push_back(mk(0, 0, 0));
    wait_drain("t5a");
    chk("t5_y0_zero", 32'(bus.y0_bo), 0);
    rq[0].push_back(mk(10, 10, 0));
    wait_drain("t5b");
    chk("t5_y0_100", 32'(bus.y0_bo), 100);

    // Zero and maximum operands on client 1, client 0 result held
    rq[1].push_back(mk(0, 255, 0));
    wait_drain("t6a");
    chk("t6_y1_zero", 32'(bus.y1_bo), 0);
    chk("t6_y0_held", 32'(bus.y0_bo), 100);
    rq[1].push_back(mk(255, 1, 0));
    wait_drain("t6b");
    chk("t6_y1_255", 32'(bus.y1_bo), 255);
    chk("t6_y0_held2", 32'(bus.y0_bo), 100);

    // Random traffic
    for (int i = 0; i < 24; i++) begin
      rq[$urandom_range(0, 1)].push_back(
        mk(int'($urandom_range(0, 255)), int'($urandom_range(0, 255)), 0));
      repeat ($urandom_range(0, 6)) @(posedge clk);
    end
    wait_drain("t7");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mult_arbiter.md
Name: mult_arbiter

Overview:
- Shares one `mult` instance (8x8 -> 16, start/busy handshake) between two requesters, for example `sqr` and a second arithmetic unit.
- Each requester sees a private, mult-like port: operands, start pulse, busy, result.
- The arbiter queues one request per client, grants round-robin, sequences the mult handshake and routes the result back to the winner.
- Sits between the clients and `mult` at the top level of the function-unit datapath.

Parameters:
- WIDTH, 8, operand width; result width is 2*WIDTH.

Ports:
- clk_i  in  1  clock; all state changes on the rising edge.
- rst_i  in  1  reset, asynchronous, active-high.
- a0_bi  in  WIDTH  client 0 operand A.
- b0_bi  in  WIDTH  client 0 operand B.
- start0_i  in  1  client 0 request pulse.
- busy0_o  out  1  client 0 request pending or in service.
- y0_bo  out  2*WIDTH  client 0 product, held until the next client 0 completion.
- a1_bi, b1_bi, start1_i, busy1_o, y1_bo  same as client 0, for client 1.
- mul_a_bo  out  WIDTH  operand A to mult.
- mul_b_bo  out  WIDTH  operand B to mult.
- mul_start_o  out  1  start pulse to mult.
- mul_busy_i  in  1  mult busy.
- mul_y_bi  in  2*WIDTH  mult product.

Behaviour:
- Reset (async, immediate):
  - FSM goes to IDLE; both pending flags clear.
  - busy0_o, busy1_o, mul_start_o = 0.
  - y0_bo, y1_bo, mul_a_bo, mul_b_bo = 0.
  - last_grant = 1, so client 0 wins the first tie.
- Request capture:
  - On an edge where start_k_i = 1 and busy_k_o = 0, latch a_k/b_k into slot k and set pending_k.
  - busy_k_o is registered and equals pending_k, so it goes high the cycle after the start.
  - start_k_i while busy_k_o = 1 is ignored: operands are not overwritten and no extra request is queued.
  - Operands need to be valid only in the start cycle.
- FSM states: IDLE, ISSUE, WAIT_BUSY, WAIT_DONE.
  - IDLE: if any pending, choose grant g:
    - only one pending -> that client;
    - both pending -> the client != last_grant.
    - Register mul_a_bo/mul_b_bo from slot g, set mul_start_o = 1, go to ISSUE.
    - A request captured on the same edge is visible in IDLE the next cycle.
  - ISSUE: mul_start_o = 0 (start is exactly one cycle wide). Operands stay stable until completion. Go to WAIT_BUSY.
  - WAIT_BUSY: stay until mul_busy_i = 1, then go to WAIT_DONE. This tolerates a mult busy rising 1 or more cycles after start.
  - WAIT_DONE: on the first cycle with mul_busy_i = 0:
    - y_g_bo <= mul_y_bi;
    - clear pending_g (busy_g_o falls the next cycle, with y_g valid in the same cycle);
    - last_grant <= g;
    - go to IDLE.
- Isolation: the other client's y and busy are unaffected by a completion.
- Minimum service:
  - 3 arbiter cycles of overhead (IDLE issue, ISSUE, final WAIT_DONE) plus the mult busy duration.
  - With both pending, the second grant is issued one cycle after the first completion.
- Fairness:
  - With continuous requests from both clients, grants alternate 0,1,0,1.
  - A lone requester may be granted repeatedly.
- Simultaneous events:
  - The client being serviced may issue a new start only after its busy falls.
  - The other client may start at any time while its own busy is low; it is queued.
- Reset mid-operation:
  - All pending work is dropped; the client results return to 0.
  - Reset does not affect the mult itself, so the mult must be on the same reset. No recovery is required for an unreset mult.
- Arithmetic: no transformation; products are passed through at 2*WIDTH bits unmodified.

Decomposition:
- Package mult_arbiter_pkg holds:
  - the state encoding localparams (IDLE = 0, ISSUE = 1, WAIT_BUSY = 2, WAIT_DONE = 3);
  - client index constants CL0 = 0, CL1 = 1.
- Sub-module mult_arb_slot is instantiated twice. It contains:
  - the operand registers, the pending flag and the busy_o driver;
  - the result register, with capture/complete strobes from the FSM.
- The FSM, round-robin pointer and mux stay in mult_arbiter.

Test Plan:
- Single request: client 0 starts with 13,11 -> mul_start_o is a one-cycle pulse with mul_a = 13, mul_b = 11; busy0_o stays high until y0_bo = 143; busy1_o stays 0 and y1_bo stays 0 throughout.
- Simultaneous start right after reset: client 0 = 255,255 and client 1 = 54,54 -> client 0 is served first with y0 = 65025, then client 1 with y1 = 2916; the second mul_start_o occurs one cycle after the first completion.
- Both clients restart immediately after each completion for 6 transactions -> grant order 0,1,0,1,0,1; every result is correct (for example 3*7 = 21 and 9*9 = 81).
- Client 1 re-asserts start1 with 2,2 while busy1 = 1 from 4,5 -> y1 = 20 and only one mult transaction occurs.
- rst_i asserted during WAIT_DONE of a 100*2 request -> all outputs go to 0 immediately without waiting for a clock; after release, a new request 0*0 completes with y = 0, and 10*10 gives 100.
- Zero and maximum operands through client 1: 0*255 = 0 and 255*1 = 255 -> y0_bo is held unchanged from its previous value.
